// File: rtl/rt_burst_sequencer.sv
// rtl/rt_burst_sequencer.sv - burst access engine: one start command becomes LEN strided single-word memory accesses
// Modes: write, read, read-compare (readback checked against a streamed expected word, mismatches counted).
module rt_burst_sequencer #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int STRIDE     = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [1:0]            mode_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [3:0]            be_i,
    input  logic                  abort_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  din_valid_i,
    output logic                  din_ready_o,
    output logic                  en_ab_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  write_en_o,
    output logic [3:0]            be_o,
    input  logic [DATA_WIDTH-1:0] r_data_i,
    input  logic                  r_valid_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  dout_valid_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_timeout_o,
    output logic [LEN_WIDTH-1:0]  mismatch_cnt_o
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] MODE_WRITE   = 2'b00;
    localparam logic [1:0] MODE_COMPARE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  state_nx;

    logic [1:0]              mode_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LEN_WIDTH-1:0]    remaining_q;
    logic [3:0]              be_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   expect_q;
    logic [DATA_WIDTH-1:0]   dout_q;
    logic                    dout_valid_q;
    logic                    abort_q;
    logic                    r_valid_prev;
    logic                    err_q;
    logic [LEN_WIDTH-1:0]    mismatch_q;
    logic [TW-1:0]           tmo_cnt;

    logic                    is_write;
    logic                    is_compare;
    logic                    start_fetches;
    logic                    r_rise;
    logic                    timeout_hit;
    logic                    last_word;

    assign is_write      = (mode_q == MODE_WRITE);
    assign is_compare    = (mode_q == MODE_COMPARE);
    assign start_fetches = (mode_i == MODE_WRITE) || (mode_i == MODE_COMPARE);
    assign r_rise        = r_valid_i & ~r_valid_prev;
    // A completion edge arriving on the final count still wins over the timeout.
    assign timeout_hit   = (state == S_WAIT) && !r_rise && (tmo_cnt == TW'(TIMEOUT - 1));
    assign last_word     = (remaining_q == LEN_WIDTH'(1)) || abort_q || abort_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        state_nx = S_DONE;
                    end else if (start_fetches) begin
                        state_nx = S_FETCH;
                    end else begin
                        state_nx = S_ISSUE;
                    end
                end
            end
            S_FETCH: begin
                if (din_valid_i) begin
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT: begin
                if (r_rise) begin
                    state_nx = S_GAP;
                end else if (timeout_hit) begin
                    state_nx = S_DONE;
                end
            end
            S_GAP: begin
                if (last_word) begin
                    state_nx = S_DONE;
                end else if (is_write || is_compare) begin
                    state_nx = S_FETCH;
                end else begin
                    state_nx = S_ISSUE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        din_ready_o = (state == S_FETCH);
        en_ab_o     = (state == S_ISSUE);
        write_en_o  = is_write && ((state == S_ISSUE) || (state == S_WAIT));
        busy_o      = (state != S_IDLE);
        done_o      = (state == S_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q       <= '0;
            addr_q       <= '0;
            remaining_q  <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            expect_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            abort_q      <= 1'b0;
            r_valid_prev <= 1'b0;
            err_q        <= 1'b0;
            mismatch_q   <= '0;
            tmo_cnt      <= '0;
        end else begin
            // The edge register tracks r_valid_i in every state so a level left high is never seen as a new completion.
            r_valid_prev <= r_valid_i;
            dout_valid_q <= 1'b0;
            if (abort_i && state != S_IDLE) begin
                abort_q <= 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    if (start_i) begin
                        mode_q      <= mode_i;
                        addr_q      <= base_addr_i;
                        remaining_q <= len_i;
                        be_q        <= be_i;
                        mismatch_q  <= '0;
                        err_q       <= 1'b0;
                        abort_q     <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (din_valid_i) begin
                        if (is_write) begin
                            wdata_q <= din_i;
                        end else begin
                            expect_q <= din_i;
                        end
                    end
                end
                S_ISSUE: tmo_cnt <= '0;
                S_WAIT: begin
                    if (r_rise) begin
                        if (!is_write) begin
                            dout_q       <= r_data_i;
                            dout_valid_q <= 1'b1;
                        end
                        if (is_compare && (r_data_i != expect_q) && (mismatch_q != '1)) begin
                            mismatch_q <= mismatch_q + LEN_WIDTH'(1);
                        end
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_GAP: begin
                    addr_q      <= addr_q + ADDR_WIDTH'(STRIDE);
                    remaining_q <= remaining_q - LEN_WIDTH'(1);
                end
                S_DONE: ;
                default: ;
            endcase
        end
    end

    assign addr_o         = addr_q;
    assign wdata_o        = wdata_q;
    assign be_o           = be_q;
    assign dout_o         = dout_q;
    assign dout_valid_o   = dout_valid_q;
    assign err_timeout_o  = err_q;
    assign mismatch_cnt_o = mismatch_q;

endmodule
